// File: rtl/addmod_arbiter_pkg.sv
// Shared types and constants for the addmod_arbiter block.
package addmod_arb_pkg;

  localparam int ADDMOD_DEFAULT_W = 192;

  // Pipeline occupancy, encoded as {s2_valid, s1_valid}
  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    S1ONLY = 2'b01,
    S2ONLY = 2'b10,
    FULL   = 2'b11
  } occ_e;

  // Requester index width; never narrower than one bit
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addmod_arbiter_addmod.sv
// Combinational modular adder: r = (a + b) mod m, valid for a, b < m.
module addMod #(
  parameter int W = 192
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  output logic [W-1:0] r
);

  logic [W:0] sum;
  logic [W:0] diff;

  // Keep the carry so a wrapped sum still compares correctly against m
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = sum - {1'b0, m};
    r    = (sum >= {1'b0, m}) ? diff[W-1:0] : sum[W-1:0];
  end

endmodule

// File: rtl/addmod_arbiter_rr.sv
// Round-robin grant: search upward from ptr with wrap, first valid wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner
);

  int   idx;
  logic found;

  // Priority scan rotated by ptr; grant is suppressed when not enabled
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
    if (enable && found) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/addmod_arbiter.sv
// addmod_arbiter: shares one modular adder among NUM_REQ requesters.
// S1 registers the winning operands, S2 registers (A+B) mod M.
// Optional macro ADDMOD_ARB_RANGE_CHECK_EN adds operand range checking
// that flags res_err and zeroes res_data for out-of-range operands.
module addmod_arbiter
  import addmod_arb_pkg::*;
#(
  parameter int DATA_WIDTH = ADDMOD_DEFAULT_W,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_opA,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_opB,
  input  logic [DATA_WIDTH-1:0]         opM,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [DATA_WIDTH-1:0]         res_data,
  output logic [ID_W-1:0]               res_id,
  output logic                          res_err,
  output logic                          busy
);

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] opa_vec, opb_vec;
  assign opa_vec = req_opA;
  assign opb_vec = req_opB;

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_opa_q, s1_opa_d;
  logic [DATA_WIDTH-1:0] s1_opb_q, s1_opb_d;
  logic [ID_W-1:0]       s1_id_q, s1_id_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic [ID_W-1:0]       res_id_q, res_id_d;
  logic                  res_err_q, res_err_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;

  logic                  advance;
  logic                  s1_can_acc;
  logic                  accept;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       win_id;
  logic [DATA_WIDTH-1:0] sum_mod;
  logic                  rng_err;
  occ_e                  occ;

  assign advance    = !res_valid_q || res_ready;
  assign s1_can_acc = (advance || !s1_valid_q) && !rst;
  assign accept     = |grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .enable (s1_can_acc),
    .grant  (grant),
    .winner (win_id)
  );

  addMod #(
    .W (DATA_WIDTH)
  ) u_addmod (
    .a (s1_opa_q),
    .b (s1_opb_q),
    .m (opM),
    .r (sum_mod)
  );

`ifdef ADDMOD_ARB_RANGE_CHECK_EN
  // Operands at or above the modulus give a meaningless sum; flag them
  always_comb begin
    rng_err = (s1_opa_q >= opM) || (s1_opb_q >= opM);
  end
`else
  assign rng_err = 1'b0;
`endif

  // Next-state for both stages and the round-robin pointer
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_opa_d    = s1_opa_q;
    s1_opb_d    = s1_opb_q;
    s1_id_d     = s1_id_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_err_d   = res_err_q;
    ptr_d       = ptr_q;

    if (advance) begin
      res_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_data_d = rng_err ? '0 : sum_mod;
        res_id_d   = s1_id_q;
        res_err_d  = rng_err;
      end
    end

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_opa_d   = opa_vec[win_id];
      s1_opb_d   = opb_vec[win_id];
      s1_id_d    = win_id;
      ptr_d      = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end
  end

  // Pipeline and pointer registers; reset discards anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_opa_q    <= '0;
      s1_opb_q    <= '0;
      s1_id_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_err_q   <= 1'b0;
      ptr_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_opa_q    <= s1_opa_d;
      s1_opb_q    <= s1_opb_d;
      s1_id_q     <= s1_id_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      res_err_q   <= res_err_d;
      ptr_q       <= ptr_d;
    end
  end

  assign occ       = occ_e'({res_valid_q, s1_valid_q});
  assign busy      = (occ != EMPTY);
  assign req_ready = grant;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_addmod_arbiter.sv
// Scoreboard bench for addmod_arbiter (DATA_WIDTH=8, NUM_REQ=4, opM=97).
module tb_addmod_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int IW = 2;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } op_t;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          err;
    bit            lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*DW-1:0] req_opA;
  logic [NR*DW-1:0] req_opB;
  logic [DW-1:0]    opM;
  logic             res_valid;
  logic             res_ready;
  logic [DW-1:0]    res_data;
  logic [IW-1:0]    res_id;
  logic             res_err;
  logic             busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  op_t  stim_q [NR][$];
  exp_t exp_q [$];
  int   acc_q [$];
  int   ncyc;

  addmod_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_opA(req_opA), .req_opB(req_opB), .opM(opM), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int id, input int data, input bit err, input bit lat);
    exp_t e;
    e.id = IW'(id); e.data = DW'(data); e.err = err; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic add_op(input int r, input int a, input int b);
    op_t o;
    o.a = DW'(a); o.b = DW'(b);
    stim_q[r].push_back(o);
  endtask

  function automatic bit pending();
    for (int i = 0; i < NR; i++) if (stim_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Present each requester's queue head; pop on handshake. Entered at posedge+#1.
  task automatic run_feed(output int cycles);
    logic [NR-1:0] acc;
    cycles = 0;
    while (pending()) begin
      if (cycles >= 200) begin
        chk("feed_timeout", 64'(cycles), 64'd0);
        for (int i = 0; i < NR; i++) stim_q[i].delete();
        break;
      end
      for (int i = 0; i < NR; i++) begin
        if (stim_q[i].size() != 0) begin
          req_valid[i] = 1'b1;
          req_opA[i*DW +: DW] = stim_q[i][0].a;
          req_opB[i*DW +: DW] = stim_q[i][0].b;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      @(negedge clk);
      acc = req_valid & req_ready;
      if (acc != '0) acc_q.push_back(cyc);
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) if (acc[i]) void'(stim_q[i].pop_front());
      cycles++;
    end
    req_valid = '0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: every result transfer pops the scoreboard and compares
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'(res_id), 64'd9);
      end else begin
        exp_t e;
        int a;
        e = exp_q.pop_front();
        chk("res_id", 64'(res_id), 64'(e.id));
        chk("res_data", 64'(res_data), 64'(e.data));
        chk("res_err", 64'(res_err), 64'(e.err));
        if (acc_q.size() != 0) begin
          a = acc_q.pop_front();
          if (e.lat) chk("latency", 64'(cyc - a), 64'd2);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; res_ready = 1'b1; req_valid = '0;
    req_opA = '0; req_opB = '0; opM = 8'd97;
    repeat (2) @(posedge clk); #1;
    req_valid = '1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    req_valid = '0; rst = 1'b0;
    @(negedge clk);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_res_id", 64'(res_id), 64'd0);
    chk("rst_res_err", 64'(res_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;

    // Single requester sequence
    add_op(0, 50, 60); push_exp(0, 13, 1'b0, 1'b1);
    add_op(0, 10, 20); push_exp(0, 30, 1'b0, 1'b1);
    add_op(0, 96, 96); push_exp(0, 95, 1'b0, 1'b1);
    add_op(0, 0, 0);   push_exp(0, 0, 1'b0, 1'b1);
    run_feed(ncyc);
    chk("single_cycles", 64'(ncyc), 64'd4);
    drain();

    // Move pointer back to 0 via requester 3
    add_op(3, 10, 3); push_exp(3, 13, 1'b0, 1'b1);
    run_feed(ncyc);
    drain();

    // All four requesters continuously valid: 0,1,2,3,0,1,2,3
    add_op(0, 1, 2);   add_op(0, 40, 57);
    add_op(1, 10, 10); add_op(1, 96, 2);
    add_op(2, 30, 30); add_op(2, 50, 50);
    add_op(3, 0, 5);   add_op(3, 80, 20);
    push_exp(0, 3, 1'b0, 1'b1);  push_exp(1, 20, 1'b0, 1'b1);
    push_exp(2, 60, 1'b0, 1'b1); push_exp(3, 5, 1'b0, 1'b1);
    push_exp(0, 0, 1'b0, 1'b1);  push_exp(1, 1, 1'b0, 1'b1);
    push_exp(2, 3, 1'b0, 1'b1);  push_exp(3, 3, 1'b0, 1'b1);
    run_feed(ncyc);
    chk("rr_cycles", 64'(ncyc), 64'd8);
    drain();

    // Backpressure: three pending requests, result port stalled 5 cycles
    res_ready = 1'b0;
    add_op(0, 5, 6); add_op(1, 7, 8); add_op(2, 9, 9);
    push_exp(0, 11, 1'b0, 1'b0); push_exp(1, 15, 1'b0, 1'b0); push_exp(2, 18, 1'b0, 1'b0);
    fork
      run_feed(ncyc);
      begin
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          if (s >= 2) begin
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_res_valid", 64'(res_valid), 64'd1);
            chk("bp_res_data", 64'(res_data), 64'd11);
            chk("bp_res_id", 64'(res_id), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
          end
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
      end
    join
    drain();

    // Pointer to 2 via requester 1, then sparse 1/3 arbitration
    add_op(1, 4, 4); push_exp(1, 8, 1'b0, 1'b1);
    run_feed(ncyc);
    drain();
    add_op(3, 20, 30); add_op(3, 1, 95); add_op(1, 60, 60);
    push_exp(3, 50, 1'b0, 1'b1); push_exp(1, 23, 1'b0, 1'b1); push_exp(3, 96, 1'b0, 1'b1);
    run_feed(ncyc);
    drain();

    // Fill both stages, then reset: contents are dropped, pointer returns to 0
    res_ready = 1'b0;
    add_op(0, 1, 1); add_op(1, 2, 2);
    run_feed(ncyc);
    @(negedge clk);
    chk("full_busy", 64'(busy), 64'd1);
    chk("full_res_valid", 64'(res_valid), 64'd1);
    @(posedge clk); #1;
    acc_q.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_res_valid", 64'(res_valid), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    add_op(1, 3, 4); add_op(2, 5, 6);
    push_exp(1, 7, 1'b0, 1'b1); push_exp(2, 11, 1'b0, 1'b1);
    run_feed(ncyc);
    drain();

    // Out-of-range operand
    add_op(0, 97, 1);
`ifdef ADDMOD_ARB_RANGE_CHECK_EN
    push_exp(0, 0, 1'b1, 1'b1);
`else
    push_exp(0, 1, 1'b0, 1'b1);
`endif
    run_feed(ncyc);
    drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addmod_arbiter.md
# addmod_arbiter

Round-robin scheduler that shares one modular adder, computing (opA + opB) mod opM, among NUM_REQ requesters. Each requester presents an operand pair over a valid/ready handshake. The arbiter registers the winner's operands, computes the modular sum in a second pipeline stage, and returns the result with the requester index over a single valid/ready result port. It sits between the point-arithmetic sequencers and the modular datapath, so that several callers can use one 192-bit adder.

## Interface
- DATA_WIDTH, 192, operand/modulus/result width
- NUM_REQ, 4, number of requesters (≥2)
- ID_W, $clog2(NUM_REQ), requester index width
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester operand valid
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high
- req_opA  input  NUM_REQ*DATA_WIDTH  packed operand A, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_opB  input  NUM_REQ*DATA_WIDTH  packed operand B, same packing
- opM  input  DATA_WIDTH  shared modulus; must be stable while busy=1
- res_valid  output  1  result valid
- res_ready  input  1  result consumer ready
- res_data  output  DATA_WIDTH  (opA+opB) mod opM
- res_id  output  ID_W  index of the requester that owns res_data
- res_err  output  1  range-check flag (see Configuration)
- busy  output  1  high while either pipeline stage holds data

## Operation
- Two stages. S1 is the operand register (s1_valid, s1_opA, s1_opB, s1_id). S2 is the result register (res_valid, res_data, res_id, res_err).
- advance = !res_valid || res_ready. S2 loads from S1 when advance.
- S1 accepts a new request when advance, or when !s1_valid, since an empty S1 can always fill.
- Occupancy states: EMPTY (no valid), S1ONLY, S2ONLY, FULL. busy = s1_valid || res_valid.
- Arbitration is combinational over req_valid. The search starts at pointer ptr and proceeds upward with wrap. The first valid index wins: grant one-hot.
- req_ready = grant when S1 can accept, else 0. req_ready may depend on req_valid. Requesters must hold valid and operands stable until accepted.
- On accept, ptr ← (winner+1) mod NUM_REQ. ptr is unchanged when there is no accept.
- Arithmetic: sum is DATA_WIDTH+1 bits (carry kept). Result = sum − opM if sum ≥ opM, else sum. This is correct for opA, opB < opM.
- A single requester holding valid continuously is accepted on every cycle that S1 can accept.
- Simultaneous S1 accept and S2 drain in the same cycle is legal. Full throughput is one result per cycle.

## Timing
- Reset values: res_valid=0, res_data=0, res_id=0, res_err=0, s1_valid=0, ptr=0, busy=0. req_ready=0 during rst.
- Reset mid-operation discards both stages. In-flight requests are not returned.
- Latency: accept in cycle N, res_valid high in cycle N+2 when no stall occurs.
- Backpressure: while res_valid && !res_ready, S2 holds its value. S1 holds if valid. req_ready=0 if S1 is full.
- res_data, res_id and res_err are stable while res_valid && !res_ready.
- The transfer occurs on a cycle with res_valid && res_ready.

## Configuration
- ADDMOD_ARB_RANGE_CHECK_EN defined: at S1→S2 transfer, if s1_opA ≥ opM or s1_opB ≥ opM, then res_err=1 and res_data=0. Otherwise res_err=0.
- ADDMOD_ARB_RANGE_CHECK_EN undefined: no comparators are built and res_err is tied to 0. res_data is the unchecked formula.

## Structure
- Package addmod_arb_pkg holds:
  - the occupancy-state enum (EMPTY, S1ONLY, S2ONLY, FULL), used for debug and coverage;
  - a helper function for ID_W;
  - the default width constant 192.
- Sub-module rr_arbiter holds the round-robin grant logic: inputs req, ptr, enable; outputs one-hot grant and winner index.
- The modular-add datapath is the existing combinational addMod module, instantiated once in S2's input path.

## Test plan
- Single requester, DATA_WIDTH=8, opM=97, sequence:
  - req0 A=50, B=60 → res_data=13, res_id=0, exactly 2 cycles after accept.
  - A=10, B=20 → 30.
  - A=96, B=96 → 95.
  - A=0, B=0 → 0.
- All 4 requesters valid continuously, res_ready=1, ptr=0 → grants 0,1,2,3,0,… One result per cycle, with res_id in the same order.
- Backpressure: res_ready=0 for 5 cycles with 3 requests pending:
  - S1 and S2 fill, and req_ready goes to 0;
  - res_data and res_id are stable throughout;
  - after release, all 3 results are delivered in order with none lost or duplicated.
- Sparse arbitration: only req1 and req3 valid, ptr=2 → req3 granted first, then req1, then req3.
- rst asserted while FULL → the next cycle has res_valid=0, busy=0, ptr=0. A request after reset completes normally.
- With ADDMOD_ARB_RANGE_CHECK_EN: A=97, B=1, opM=97 → res_err=1, res_data=0. Without the macro, the same stimulus → res_err=0, res_data=1.
